// File: rtl/clock_pkg.sv
// Shared encodings for the clock slice: key_module modes, adjust field selects, BCD limits.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'b00,
    MODE_ALARM     = 2'b01,
    MODE_STOPWATCH = 2'b10,
    MODE_ADJUST    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SHIF_SEC  = 2'b00,
    SHIF_MIN  = 2'b01,
    SHIF_HOUR = 2'b10,
    SHIF_NONE = 2'b11
  } field_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with independent up/down steps.
// Digits are stepped individually, so no binary-to-BCD conversion is needed.
// wrap_up flags that the value sits at MAX_BCD, meaning the next up-step rolls over to 00.
module bcd_mod_counter #(
  parameter logic [7:0] MAX_BCD  = 8'h59,
  parameter logic [7:0] INIT_BCD = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value,
  output logic       wrap_up
);

  logic [7:0] next_up;
  logic [7:0] next_down;

  assign wrap_up = (value == MAX_BCD);

  // Next values for one step up or down: carry/borrow between units and tens, wrap at the field limits.
  always_comb begin
    next_up   = value;
    next_down = value;
    if (value == MAX_BCD) begin
      next_up = 8'h00;
    end else if (value[3:0] == 4'h9) begin
      next_up = {value[7:4] + 4'h1, 4'h0};
    end else begin
      next_up = {value[7:4], value[3:0] + 4'h1};
    end
    if (value == 8'h00) begin
      next_down = MAX_BCD;
    end else if (value[3:0] == 4'h0) begin
      next_down = {value[7:4] - 4'h1, 4'h9};
    end else begin
      next_down = {value[7:4], value[3:0] - 4'h1};
    end
  end

  // Register the field; simultaneous up and down cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= INIT_BCD;
    end else if (inc && !dec) begin
      value <= next_up;
    end else if (dec && !inc) begin
      value <= next_down;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Timekeeping core: 1 Hz divider, HH:MM:SS in BCD, adjust-mode key handling, midnight carry.
// Optional build macro ADJUST_FREEZE_EN: when defined, the divider is held and ticks are
// suppressed for as long as model is in adjust mode; otherwise time keeps running.
module time_keeper
  import clock_pkg::*;
#(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter logic [7:0] INIT_HOUR = 8'h12,
  parameter logic [7:0] INIT_MIN  = 8'h00,
  parameter logic [7:0] INIT_SEC  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] model,
  input  logic [1:0] adjust_shif,
  input  logic       key_up,
  input  logic       key_down,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick_1hz,
  output logic       day_carry
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pending_tick;
  logic             freeze;
  logic             tick_int;
  logic             adjust_active;
  logic             key_ok;
  logic             apply_tick;
  logic             sel_sec, sel_min, sel_hour;
  logic             sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic             sec_wrap, min_wrap, hour_wrap;

`ifdef ADJUST_FREEZE_EN
  assign freeze = (model == MODE_ADJUST);
`else
  assign freeze = 1'b0;
`endif

  assign tick_int      = !freeze && (div_cnt == DIV_LAST);
  assign adjust_active = (model == MODE_ADJUST) && (adjust_shif != SHIF_NONE);
  assign key_ok        = adjust_active && (key_up != key_down);

  // An accepted key takes the cycle; any tick arriving then waits in pending_tick.
  assign apply_tick = !key_ok && !freeze && (tick_int || pending_tick);

  assign sel_sec  = key_ok && (adjust_shif == SHIF_SEC);
  assign sel_min  = key_ok && (adjust_shif == SHIF_MIN);
  assign sel_hour = key_ok && (adjust_shif == SHIF_HOUR);

  assign sec_inc  = apply_tick || (sel_sec && key_up);
  assign sec_dec  = sel_sec && key_down;
  assign min_inc  = (apply_tick && sec_wrap) || (sel_min && key_up);
  assign min_dec  = sel_min && key_down;
  assign hour_inc = (apply_tick && sec_wrap && min_wrap) || (sel_hour && key_up);
  assign hour_dec = sel_hour && key_down;

  bcd_mod_counter #(.MAX_BCD(BCD_59), .INIT_BCD(INIT_SEC)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc    (sec_inc),
    .dec    (sec_dec),
    .value  (sec_bcd),
    .wrap_up(sec_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59), .INIT_BCD(INIT_MIN)) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc    (min_inc),
    .dec    (min_dec),
    .value  (min_bcd),
    .wrap_up(min_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_23), .INIT_BCD(INIT_HOUR)) u_hour (
    .clk    (clk),
    .rst    (rst),
    .inc    (hour_inc),
    .dec    (hour_dec),
    .value  (hour_bcd),
    .wrap_up(hour_wrap)
  );

  // Divider, registered tick/carry pulses and the one-deep deferred tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      tick_1hz     <= 1'b0;
      day_carry    <= 1'b0;
      pending_tick <= 1'b0;
    end else begin
      if (freeze || (div_cnt == DIV_LAST)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      tick_1hz  <= tick_int;
      day_carry <= apply_tick && sec_wrap && min_wrap && hour_wrap;
      if (freeze) begin
        pending_tick <= 1'b0;
      end else if (key_ok) begin
        pending_tick <= pending_tick || tick_int;
      end else begin
        pending_tick <= pending_tick && tick_int;
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_FREQ=10 and reset time 23:59:58.
// Expected values are hand-computed; the bench follows whichever ADJUST_FREEZE_EN build it is compiled with.
module tb_time_keeper;

  logic       clk;
  logic       rst;
  logic [1:0] model;
  logic [1:0] adjust_shif;
  logic       key_up;
  logic       key_down;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       tick_1hz;
  logic       day_carry;

  int passCount  = 0;
  int checkCount = 0;
  int tickSeen   = 0;
  int carrySeen  = 0;

  time_keeper #(
    .CLK_FREQ (10),
    .INIT_HOUR(8'h23),
    .INIT_MIN (8'h59),
    .INIT_SEC (8'h58)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .model      (model),
    .adjust_shif(adjust_shif),
    .key_up     (key_up),
    .key_down   (key_down),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .tick_1hz   (tick_1hz),
    .day_carry  (day_carry)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, sampling 1 unit after each and counting output pulses.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tick_1hz === 1'b1) tickSeen++;
      if (day_carry === 1'b1) carrySeen++;
    end
  endtask

  // Present one key combination for a single edge, then release the keys.
  task automatic applyStimulus(input logic up, input logic down);
    key_up   = up;
    key_down = down;
    runCycles(1);
    key_up   = 1'b0;
    key_down = 1'b0;
  endtask

  // Compare one observation against its hand-computed value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Synchronous reset for two edges; the first edge after release is edge 1 of the divider.
  task automatic doReset();
    rst = 1'b1;
    runCycles(2);
    rst = 1'b0;
    tickSeen  = 0;
    carrySeen = 0;
  endtask

  function automatic logic [31:0] hms();
    return {8'h00, hour_bcd, min_bcd, sec_bcd};
  endfunction

  initial begin
    rst         = 1'b1;
    model       = 2'b00;
    adjust_shif = 2'b11;
    key_up      = 1'b0;
    key_down    = 1'b0;

    // Reset state and free-running rollover through midnight.
    doReset();
    checkOutput("reset_time", hms(), 32'h00235958);
    checkOutput("reset_tick", {31'd0, tick_1hz}, 32'd0);
    checkOutput("reset_carry", {31'd0, day_carry}, 32'd0);
    runCycles(9);
    checkOutput("hold_9", hms(), 32'h00235958);
    runCycles(1);
    checkOutput("tick_10_time", hms(), 32'h00235959);
    checkOutput("tick_10_pulse", {31'd0, tick_1hz}, 32'd1);
    runCycles(10);
    checkOutput("midnight_time", hms(), 32'h00000000);
    checkOutput("midnight_carry", {31'd0, day_carry}, 32'd1);
    runCycles(1);
    checkOutput("carry_one_cycle", {31'd0, day_carry}, 32'd0);
    checkOutput("tick_count_21", tickSeen, 32'd2);
    checkOutput("carry_count_21", carrySeen, 32'd1);

    // Minute adjust wraps 59->00 without touching hours.
    doReset();
    model       = 2'b11;
    adjust_shif = 2'b01;
    applyStimulus(1'b1, 1'b0);
    checkOutput("min_up_wrap", hms(), 32'h00230058);
    applyStimulus(1'b1, 1'b0);
    checkOutput("min_up_01", hms(), 32'h00230158);
    applyStimulus(1'b1, 1'b0);
    checkOutput("min_up_02", hms(), 32'h00230258);

    // Hour adjust wraps both ways; both keys or the none field change nothing.
    adjust_shif = 2'b10;
    applyStimulus(1'b1, 1'b0);
    checkOutput("hour_up_wrap", hms(), 32'h00000258);
    applyStimulus(1'b0, 1'b1);
    checkOutput("hour_down_wrap", hms(), 32'h00230258);
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_keys", hms(), 32'h00230258);
    adjust_shif = 2'b11;
    applyStimulus(1'b1, 1'b0);
    checkOutput("shif_none", hms(), 32'h00230258);

    // Second adjust wraps 59->00 with no carry into minutes.
    adjust_shif = 2'b00;
    applyStimulus(1'b1, 1'b0);
    checkOutput("sec_up_59", hms(), 32'h00230259);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sec_up_wrap", hms(), 32'h00230200);
    checkOutput("adjust_no_carry", carrySeen, 32'd0);

    // Keys are ignored outside adjust mode; normal ticking continues.
    doReset();
    model       = 2'b10;
    adjust_shif = 2'b00;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("stopwatch_keys", hms(), 32'h00235958);
    runCycles(7);
    checkOutput("stopwatch_tick", hms(), 32'h00235959);
    checkOutput("stopwatch_ticks", tickSeen, 32'd1);

    // Run 32 seconds to 00:00:30, then collide a second key-up with the tick.
    doReset();
    model = 2'b00;
    runCycles(320);
    checkOutput("run_320", hms(), 32'h00000030);
    checkOutput("run_320_ticks", tickSeen, 32'd32);
    checkOutput("run_320_carry", carrySeen, 32'd1);
    model       = 2'b11;
    adjust_shif = 2'b00;
    runCycles(9);
    checkOutput("pre_collide", hms(), 32'h00000030);
    applyStimulus(1'b1, 1'b0);
    checkOutput("collide_key", hms(), 32'h00000031);
`ifdef ADJUST_FREEZE_EN
    checkOutput("collide_tick", {31'd0, tick_1hz}, 32'd0);
    runCycles(1);
    checkOutput("collide_pending", hms(), 32'h00000031);
`else
    checkOutput("collide_tick", {31'd0, tick_1hz}, 32'd1);
    runCycles(1);
    checkOutput("collide_pending", hms(), 32'h00000032);
`endif

    // Reset in the rollover cycle wins over the carry.
    model       = 2'b00;
    adjust_shif = 2'b11;
    doReset();
    runCycles(19);
    checkOutput("pre_rollover", hms(), 32'h00235959);
    rst = 1'b1;
    runCycles(1);
    checkOutput("rst_rollover_time", hms(), 32'h00235958);
    checkOutput("rst_rollover_carry", {31'd0, day_carry}, 32'd0);
    rst = 1'b0;
    runCycles(1);
    checkOutput("post_rst_carry", {31'd0, day_carry}, 32'd0);
    checkOutput("post_rst_time", hms(), 32'h00235958);
    checkOutput("rst_rollover_count", carrySeen, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
